// File: rtl/imem_boot_loader_if.sv
// Load-stream, core-PC and instruction-memory port bundle for imem_boot_loader.
// master = stream source / core side, slave = the loader itself.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [LEN_W-1:0]  prog_len;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] core_pc;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              core_hold;
  logic              done;
  logic              error;

  modport master (
    output start, prog_len, byte_in, byte_valid, core_pc,
    input  byte_ready, mem_addr, mem_wdata, mem_we, core_hold, done, error
  );

  modport slave (
    input  start, prog_len, byte_in, byte_valid, core_pc,
    output byte_ready, mem_addr, mem_wdata, mem_we, core_hold, done, error
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Streams a little-endian program image into instruction memory, holding the core until done.
// Optional trailing checksum byte check: define IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int MEM_BYTES = 148,
  parameter int ADDR_W    = 64,
  parameter int LEN_W     = 16
) (
  input logic              clk,
  input logic              reset,
  imem_boot_loader_if.slave bus
);
  localparam int CNT_W = $clog2(MEM_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_ERROR,
    S_CHECK
`else
    S_ERROR
`endif
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] byte_cnt, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [31:0]      word_buf, buf_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif

  function automatic logic len_ok(input logic [LEN_W-1:0] len);
    return (len != '0) && (len[1:0] == 2'b00) && (32'(len) <= 32'(MEM_BYTES));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      len_q    <= '0;
      word_buf <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state    <= state_d;
      byte_cnt <= cnt_d;
      len_q    <= len_d;
      word_buf <= buf_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d        = state;
    cnt_d          = byte_cnt;
    len_d          = len_q;
    buf_d          = word_buf;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d          = sum_q;
`endif
    bus.byte_ready = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_wdata  = '0;
    bus.mem_addr   = ADDR_W'({byte_cnt[CNT_W-1:2], 2'b00});
    bus.core_hold  = 1'b1;
    bus.done       = 1'b0;
    bus.error      = 1'b0;

    case (state)
      S_IDLE: bus.mem_addr = '0;
      S_LOAD: begin
        bus.byte_ready = 1'b1;
        if (bus.byte_valid) begin
          buf_d[{byte_cnt[1:0], 3'b000} +: 8] = bus.byte_in;
          cnt_d = byte_cnt + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + bus.byte_in;
`endif
          if (byte_cnt[1:0] == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = word_buf;
        bus.mem_addr  = ADDR_W'(byte_cnt - CNT_W'(4));
        if (byte_cnt == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_LOAD;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        bus.byte_ready = 1'b1;
        if (bus.byte_valid)
          state_d = (8'(sum_q + bus.byte_in) == 8'h00) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE: begin
        bus.core_hold = 1'b0;
        bus.done      = 1'b1;
        bus.mem_addr  = bus.core_pc;
      end
      S_ERROR: begin
        bus.error    = 1'b1;
        bus.mem_addr = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // A load may (re)start only from a resting state; a bad length is rejected outright.
    if ((state == S_IDLE || state == S_DONE || state == S_ERROR) && bus.start) begin
      if (len_ok(bus.prog_len)) begin
        state_d = S_LOAD;
        len_d   = bus.prog_len[CNT_W-1:0];
        cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = '0;
`endif
      end else begin
        state_d = S_ERROR;
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: expected writes and final status come from an image-level model.
// Follows IMEM_LOADER_CHECKSUM_EN to send and judge the trailing checksum byte.
module tb_imem_boot_loader;
  localparam int MEM_BYTES = 148;

  typedef struct {
    logic [63:0] a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_W(64), .LEN_W(16)) bus ();

  imem_boot_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(64), .LEN_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  wr_t  mon_w;
  logic [7:0] img [0:MEM_BYTES-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the next word the image model predicts.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", bus.mem_we, 0);
      end else begin
        mon_w = exp_q.pop_front();
        check("wr_addr", bus.mem_addr, mon_w.a);
        check("wr_data", bus.mem_wdata, mon_w.d);
        check("wr_ready_low", bus.byte_ready, 0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    bit acc;
    for (int g = 0; g < gap; g++) begin
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'($urandom);
      if (noise && g == 0) begin
        bus.start    = 1'b1;
        bus.prog_len = 16'd6;
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    acc = 1'b0;
    for (int t = 0; t < 16 && !acc; t++) begin
      acc = bus.byte_ready;
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    if (!acc) check("ready_timeout", bus.byte_ready, 1);
  endtask

  task automatic run_load(input int len, input int nsend, input int gap_lo, input int gap_hi,
                          input bit noise, input logic [7:0] cks);
    bit  ok;
    bit  exp_done;
    int  s;
    wr_t e;
    ok = (len > 0) && (len % 4 == 0) && (len <= MEM_BYTES);
    if (ok) begin
      for (int w = 0; 4 * w + 4 <= nsend; w++) begin
        e.a = 64'(4 * w);
        e.d = {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
        exp_q.push_back(e);
      end
    end
    bus.start    = 1'b1;
    bus.prog_len = 16'(len);
    @(negedge clk);
    bus.start = 1'b0;
    if (!ok) begin
      check("rej_error", bus.error, 1);
      check("rej_hold", bus.core_hold, 1);
      check("rej_done", bus.done, 0);
      check("rej_ready", bus.byte_ready, 0);
      repeat (2) @(negedge clk);
      check("rej_stay", bus.error, 1);
      return;
    end
    check("load_ready", bus.byte_ready, 1);
    check("load_done", bus.done, 0);
    check("load_error", bus.error, 0);
    check("load_addr", bus.mem_addr, 0);
    for (int i = 0; i < nsend; i++)
      send_byte(img[i], (i == 0) ? 0 : int'($urandom_range(gap_hi, gap_lo)), noise);
    if (nsend < len) return;
    check("lat_we", bus.mem_we, 1);
    check("lat_done_early", bus.done, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    s = int'(cks);
    for (int i = 0; i < len; i++) s += int'(img[i]);
    exp_done = (s % 256) == 0;
    send_byte(cks, 0, 1'b0);
`else
    s = 0;
    exp_done = 1'b1;
    @(negedge clk);
`endif
    check("end_done", bus.done, 64'(exp_done));
    check("end_error", bus.error, 64'(!exp_done));
    check("end_hold", bus.core_hold, 64'(!exp_done));
    check("end_ready", bus.byte_ready, 0);
    if (exp_done) begin
      bus.core_pc = {$urandom, $urandom};
      #1;
      check("pc_track", bus.mem_addr, bus.core_pc);
    end
    check("writes_left", exp_q.size(), 0);
  endtask

  function automatic logic [7:0] good_cks(input int len);
    int s;
    s = 0;
    for (int i = 0; i < len; i++) s += int'(img[i]);
    return 8'(-s);
  endfunction

  initial begin
    #5ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int len;
    logic [7:0] prog [0:7];
    bus.start      = 1'b0;
    bus.prog_len   = '0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    bus.core_pc    = '0;
    reset          = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_hold", bus.core_hold, 1);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_ready", bus.byte_ready, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);

    prog = '{8'h93, 8'h00, 8'h40, 8'h00, 8'h13, 8'h0B, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) img[i] = prog[i];
    run_load(8, 8, 0, 0, 1'b0, good_cks(8));
    bus.core_pc = 64'h24;
    #1;
    check("pc_0x24", bus.mem_addr, 64'h24);

    run_load(6, 0, 0, 0, 1'b0, 8'h00);
    run_load(152, 0, 0, 0, 1'b0, 8'h00);
    run_load(0, 0, 0, 0, 1'b0, 8'h00);

    run_load(8, 8, 2, 2, 1'b1, good_cks(8));

    for (int i = 0; i < MEM_BYTES; i++) img[i] = 8'($urandom);
    run_load(148, 5, 0, 0, 1'b0, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hold", bus.core_hold, 1);
    check("abort_ready", bus.byte_ready, 0);
    check("abort_addr", bus.mem_addr, 0);
    check("abort_done", bus.done, 0);
    check("abort_writes", exp_q.size(), 0);
    run_load(4, 4, 0, 0, 1'b0, good_cks(4));

`ifdef IMEM_LOADER_CHECKSUM_EN
    img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'h04;
    run_load(4, 4, 0, 0, 1'b0, 8'hF6);
    run_load(4, 4, 0, 0, 1'b0, 8'hF5);
`endif

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(9, 0) == 0) len = int'($urandom_range(200, 0));
      else len = 4 * int'($urandom_range(37, 1));
      for (int i = 0; i < MEM_BYTES; i++) img[i] = 8'($urandom);
      run_load(len, (len <= MEM_BYTES) ? len : 0, 0, 2, 1'b0,
               good_cks((len <= MEM_BYTES) ? len : 0) +
               (($urandom_range(1, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1))));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
